// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues sequential or redirected fetches to a
// single-cycle instruction memory and presents one entry at a time to decode.
//
// Handshake: an entry is presented while if_valid=1 and moves to decode on
// any rising edge where if_valid=1 and if_ready=1. A presented entry holds
// if_pc/if_fault/if_instr stable until it is accepted or a redirect flushes it.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0100_0000,
  parameter logic [31:0] IMEM_BASE  = 32'h0100_0000,
  parameter logic [31:0] IMEM_BYTES = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_rd,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault,
  output logic [1:0]  dbg_state
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
  logic        r_if_valid, w_if_valid_nxt;
  logic [31:0] r_if_pc, w_if_pc_nxt;
  logic        r_if_fault, w_if_fault_nxt;

  logic [31:0] w_addr;
  logic [32:0] w_addr_ext;
  logic [32:0] w_lo;
  logic [32:0] w_hi;
  logic        w_legal;
  logic        w_may_issue;
  logic        w_slot_free;
  logic        w_go;

  // Window bounds evaluated in 33 bits so a window touching 2^32 cannot wrap.
  assign w_lo       = {1'b0, IMEM_BASE};
  assign w_hi       = {1'b0, IMEM_BASE} + {1'b0, IMEM_BYTES} - 33'd4;
  assign w_addr     = redirect_valid ? redirect_pc : r_fetch_pc;
  assign w_addr_ext = {1'b0, w_addr};
  assign w_legal    = (w_addr[1:0] == 2'b00) && (w_addr_ext >= w_lo) && (w_addr_ext <= w_hi);

  // A redirect both permits an issue in any state and frees the output slot,
  // which is what flushes the presented entry and any in-flight response.
  assign w_may_issue = (r_state == S_RUN) || redirect_valid;
  assign w_slot_free = !r_if_valid || if_ready || redirect_valid;
  assign w_go        = w_may_issue && w_slot_free;

  assign imem_rd   = w_go && w_legal;
  assign imem_addr = w_addr;
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_fault  = r_if_fault;
  // Memory holds its read data while imem_rd=0, so a stalled entry stays stable.
  assign if_instr  = r_if_fault ? NOP : imem_instr;
  assign dbg_state = r_state;

  // Next-state and next-entry selection.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_if_valid_nxt = r_if_valid;
    w_if_pc_nxt    = r_if_pc;
    w_if_fault_nxt = r_if_fault;
    if (w_go) begin
      w_if_valid_nxt = 1'b1;
      w_if_pc_nxt    = w_addr;
      if (w_legal) begin
        w_if_fault_nxt = 1'b0;
        w_fetch_pc_nxt = w_addr + 32'd4;
        w_state_nxt    = S_RUN;
      end else begin
        w_if_fault_nxt = 1'b1;
        w_fetch_pc_nxt = w_addr;
        w_state_nxt    = S_HALT;
      end
    end else begin
      if (r_if_valid && if_ready) begin
        w_if_valid_nxt = 1'b0;
      end
      if (r_state == S_IDLE) begin
        w_state_nxt = S_RUN;
      end
    end
  end

  // State and presented-entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_pc    <= RESET_PC;
      r_if_fault <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_fault <= w_if_fault_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a reference model of the fetch stream
// and literal checkpoints at the notable cycles of each scenario.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC   = 32'h0100_0000;
  localparam logic [31:0] IMEM_BASE  = 32'h0100_0000;
  localparam logic [31:0] IMEM_BYTES = 32'h0000_1000;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_rd;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:1023];

  instr_fetch #(
    .RESET_PC  (RESET_PC),
    .IMEM_BASE (IMEM_BASE),
    .IMEM_BYTES(IMEM_BYTES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_rd       (imem_rd),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_fault      (if_fault),
    .dbg_state     (dbg_state)
  );

  // Clock block.
  always #5 clk = ~clk;

  // Instruction memory: one-cycle read latency, data held when not reading.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = (32'(i) << 16) | 32'h0000_0093;
  end
  always @(posedge clk) begin
    if (imem_rd) imem_instr <= mem[imem_addr[11:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    longint unsigned ua;
    longint unsigned lo;
    longint unsigned top;
    ua  = {32'd0, a};
    lo  = {32'd0, IMEM_BASE};
    top = {32'd0, IMEM_BASE} + {32'd0, IMEM_BYTES};
    return (a[1:0] == 2'b00) && (ua >= lo) && (ua + 4 <= top);
  endfunction

  // Reference model: where the stream is, and what decode is being shown.
  typedef enum int { M_IDLE, M_RUN, M_HALT } mode_t;
  mode_t       m_mode  = M_IDLE;
  logic [31:0] m_next  = RESET_PC;
  bit          m_shown = 1'b0;
  logic [31:0] m_pc    = RESET_PC;
  bit          m_bad   = 1'b0;

  // Compare process: checks every cycle mid-period, then advances the model
  // by the edge that follows (inputs are stable until after that edge).
  always @(negedge clk) begin
    logic [31:0] a;
    bit          fetching;
    bit          room;
    bit          go;
    if (!rst_n) begin
      m_mode  = M_IDLE;
      m_next  = RESET_PC;
      m_shown = 1'b0;
      m_pc    = RESET_PC;
      m_bad   = 1'b0;
    end
    a        = redirect_valid ? redirect_pc : m_next;
    fetching = (m_mode == M_RUN) || redirect_valid;
    room     = !m_shown || if_ready || redirect_valid;
    go       = rst_n && fetching && room;
    chk("imem_rd", {31'd0, imem_rd}, {31'd0, go && legal(a)});
    chk("imem_addr", imem_addr, a);
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_shown});
    if (m_shown || !rst_n) begin
      chk("if_pc", if_pc, m_pc);
      chk("if_fault", {31'd0, if_fault}, {31'd0, m_bad});
    end
    if (m_shown) chk("if_instr", if_instr, m_bad ? NOP : mem[m_pc[11:2]]);
    if (rst_n) begin
      if (go) begin
        m_shown = 1'b1;
        m_pc    = a;
        m_bad   = !legal(a);
        m_next  = m_bad ? a : a + 32'd4;
        m_mode  = m_bad ? M_HALT : M_RUN;
      end else begin
        if (m_shown && if_ready) m_shown = 1'b0;
        if (m_mode == M_IDLE) m_mode = M_RUN;
      end
    end
  end

  // Driver: change inputs just after a rising edge, return at the falling edge.
  task automatic drive(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    rst_n          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_ready       = rdy;
    @(negedge clk);
  endtask

  initial begin
    // Reset state.
    repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst if_pc", if_pc, 32'h0100_0000);
    chk("rst imem_rd", {31'd0, imem_rd}, 32'd0);

    // Release: one IDLE cycle, then streaming from RESET_PC.
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("idle no issue", {31'd0, imem_rd}, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("first issue rd", {31'd0, imem_rd}, 32'd1);
    chk("first issue addr", imem_addr, 32'h0100_0000);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("first entry valid", {31'd0, if_valid}, 32'd1);
    chk("first entry pc", if_pc, 32'h0100_0000);
    chk("first entry instr", if_instr, 32'h0000_0093);
    repeat (5) drive(1'b1, 1'b0, 32'h0, 1'b1);

    // Backpressure for three cycles.
    repeat (3) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      chk("stall pc", if_pc, 32'h0100_0018);
      chk("stall rd", {31'd0, imem_rd}, 32'd0);
    end
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("release pc", if_pc, 32'h0100_0018);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("after release pc", if_pc, 32'h0100_001C);

    // Redirect while decode stalls: stale entry is dropped.
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 32'h0100_0400, 1'b0);
    chk("redirect rd", {31'd0, imem_rd}, 32'd1);
    chk("redirect addr", imem_addr, 32'h0100_0400);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("redirect entry pc", if_pc, 32'h0100_0400);

    // Stream off the end of the window.
    drive(1'b1, 1'b1, 32'h0100_0FF0, 1'b1);
    repeat (4) drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap fault pc", if_pc, 32'h0100_1000);
    chk("wrap fault flag", {31'd0, if_fault}, 32'd1);
    chk("wrap fault instr", if_instr, 32'h0000_0013);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("halt held valid", {31'd0, if_valid}, 32'd1);
    chk("halt no issue", {31'd0, imem_rd}, 32'd0);
    repeat (2) drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("halt drained", {31'd0, if_valid}, 32'd0);
    chk("halt still idle", {31'd0, imem_rd}, 32'd0);

    // Misaligned redirect, then recovery.
    drive(1'b1, 1'b1, 32'h0100_0002, 1'b1);
    chk("misaligned rd", {31'd0, imem_rd}, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("misaligned fault", {31'd0, if_fault}, 32'd1);
    chk("misaligned pc", if_pc, 32'h0100_0002);
    drive(1'b1, 1'b1, 32'h0100_0010, 1'b1);
    chk("recover rd", {31'd0, imem_rd}, 32'd1);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("recover pc", if_pc, 32'h0100_0010);
    chk("recover fault", {31'd0, if_fault}, 32'd0);

    // Window boundaries.
    drive(1'b1, 1'b1, 32'h00FF_FFFC, 1'b1);
    chk("below base rd", {31'd0, imem_rd}, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b1, 32'h0100_0FFC, 1'b1);
    chk("top word rd", {31'd0, imem_rd}, 32'd1);
    repeat (3) drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b1, 32'h0100_0000, 1'b1);
    chk("base word rd", {31'd0, imem_rd}, 32'd1);

    // Mixed ready/redirect traffic.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] tgt;
      tgt = IMEM_BASE + (32'($urandom_range(0, 1023)) << 2);
      if ($urandom_range(0, 9) == 0) tgt = tgt + 32'd2;
      drive(1'b1, ($urandom_range(0, 7) == 0), tgt, 1'($urandom_range(0, 1)));
    end

    // Reset between edges mid-stream.
    repeat (3) drive(1'b1, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst valid", {31'd0, if_valid}, 32'd0);
    chk("async rst rd", {31'd0, imem_rd}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("refetch addr", imem_addr, 32'h0100_0000);
    chk("refetch rd", {31'd0, imem_rd}, 32'd1);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("refetch pc", if_pc, 32'h0100_0000);
    repeat (4) drive(1'b1, 1'b0, 32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0100_0000, first fetch byte address after reset.
REQ-002 Parameter IMEM_BASE, default 32'h0100_0000, lowest legal fetch byte address.
REQ-003 Parameter IMEM_BYTES, default 32'h0000_1000, legal fetch window size (4 KByte).
REQ-004 Port clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port imem_rd  out  1  read strobe to instruction memory.
REQ-007 Port imem_addr  out  32  byte address to instruction memory (word index taken by memory from bits [11:2]).
REQ-008 Port imem_instr  in  32  memory read data, valid the cycle after imem_rd=1, held while imem_rd=0.
REQ-009 Port redirect_valid  in  1  branch/jump/trap redirect request.
REQ-010 Port redirect_pc  in  32  redirect target byte address.
REQ-011 Port if_valid  out  1  fetched entry valid to decode.
REQ-012 Port if_ready  in  1  decode accepts entry.
REQ-013 Port if_pc  out  32  byte address of presented entry.
REQ-014 Port if_instr  out  32  instruction of presented entry.
REQ-015 Port if_fault  out  1  entry is a fetch fault (misaligned or out-of-window address).

Function
REQ-016 States: IDLE, RUN, HALT; IDLE->RUN unconditionally after one cycle; RUN->HALT when a fault entry is produced; HALT->RUN only on redirect_valid.
REQ-017 Issue address A = redirect_pc if redirect_valid=1, else fetch_pc register; imem_addr SHALL equal A combinationally.
REQ-018 A is legal iff A[1:0]=2'b00 and IMEM_BASE <= A <= IMEM_BASE+IMEM_BYTES-4 (unsigned, 32-bit compare, no wrap).
REQ-019 Slot free when if_valid=0, or if_valid=1 and if_ready=1, or redirect_valid=1.
REQ-020 imem_rd SHALL be 1 iff state is RUN (or HALT/IDLE with redirect_valid=1), slot free, and A legal.
REQ-021 On imem_rd=1: fetch_pc <= A+4 (mod 2^32), next cycle if_valid=1, if_pc=A, if_fault=0.
REQ-022 Fetch latency: entry for address A SHALL be presented exactly one cycle after A is issued.
REQ-023 if_instr SHALL equal imem_instr when if_fault=0, and 32'h0000_0013 (NOP) when if_fault=1.
REQ-024 Backpressure: if_valid=1 and if_ready=0 and no redirect -> imem_rd=0, if_valid/if_pc/if_fault/if_instr held stable.
REQ-025 Entry handed off when if_valid=1 and if_ready=1; if no new issue that cycle, if_valid <= 0.
REQ-026 Issue conditions met but A illegal (state RUN or redirect): imem_rd=0; next cycle if_valid=1, if_pc=A, if_fault=1; state -> HALT; fetch_pc <= A.
REQ-027 HALT: no issue; fault entry held until accepted, then if_valid <= 0; only redirect_valid leaves HALT.
REQ-028 redirect_valid SHALL be honoured in every state, same cycle: presented entry and any in-flight response discarded, no entry from the old stream presented afterward.
REQ-029 redirect_valid with if_valid=1 and if_ready=0: entry dropped, not delivered; decode treats redirect as flush.
REQ-030 Sequential wrap past window end (fetch_pc = IMEM_BASE+IMEM_BYTES) SHALL produce a fault entry per REQ-026.

Reset
REQ-031 rst_n=0 asynchronously: state=IDLE, fetch_pc=RESET_PC, if_valid=0, if_pc=RESET_PC, if_fault=0, imem_rd=0 (absent redirect).
REQ-032 Reset asserted mid-operation SHALL drop any in-flight fetch; first issue after release at RESET_PC in the cycle following IDLE.

Verification
REQ-033 Release reset, if_ready=1, memory word0=32'h0000_0093 -> cycle1 imem_rd=1 addr 0x0100_0000; cycle2 if_valid=1, if_pc=0x0100_0000, if_instr=0x0000_0093; streaming +4/cycle, no bubbles.
REQ-034 Hold if_ready=0 three cycles during stream -> imem_rd=0, if_pc/if_instr unchanged; on release next entry is if_pc+4, none skipped/duplicated.
REQ-035 redirect_valid with redirect_pc=0x0100_0400 while if_valid=1, if_ready=0 -> same cycle imem_rd=1 addr 0x0100_0400; next cycle if_pc=0x0100_0400; stale entry never accepted.
REQ-036 Stream through 0x0100_0FFC -> next entry if_pc=0x0100_1000, if_fault=1, if_instr=0x0000_0013; imem_rd stays 0 until redirect.
REQ-037 redirect_pc=0x0100_0002 -> imem_rd=0, next cycle if_fault=1, if_pc=0x0100_0002; then redirect_pc=0x0100_0010 -> RUN, normal fetch resumes.
REQ-038 Assert rst_n=0 between clock edges mid-stream -> if_valid=0 immediately; after release refetch from 0x0100_0000.
